// File: rtl/alu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : alu_iterative
// Brief    : Execute-stage ALU with valid/ready handshakes; single-cycle
//            logic/arith/compare ops, shifts iterate one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu_iterative #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ALUControl,
    input  logic [XLEN-1:0]   SrcA,
    input  logic [XLEN-1:0]   SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   ALUResult,
    output logic              Zero,
    output logic              busy
);

    localparam logic [3:0] c_ALU_NONE           = 4'b0000;
    localparam logic [3:0] c_ALU_SHIFTL         = 4'b0001;
    localparam logic [3:0] c_ALU_ADD            = 4'b0010;
    localparam logic [3:0] c_ALU_SUB            = 4'b0011;
    localparam logic [3:0] c_ALU_LESS_THAN      = 4'b0100;
    localparam logic [3:0] c_ALU_LESS_THAN_SIGNED = 4'b0101;
    localparam logic [3:0] c_ALU_SHIFTR         = 4'b0110;
    localparam logic [3:0] c_ALU_SHIFTR_ARITH   = 4'b0111;
    localparam logic [3:0] c_ALU_OR             = 4'b1000;
    localparam logic [3:0] c_ALU_AND            = 4'b1001;
    localparam logic [3:0] c_ALU_XOR            = 4'b1010;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    localparam logic [SHAMT_W-1:0] c_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [3:0]         r_ctrl;
    logic [XLEN-1:0]    r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic [XLEN-1:0]    w_comb_res;
    logic [XLEN-1:0]    w_step;

    assign w_shamt    = SrcB[SHAMT_W-1:0];
    assign w_is_shift = (ALUControl == c_ALU_SHIFTL) ||
                        (ALUControl == c_ALU_SHIFTR) ||
                        (ALUControl == c_ALU_SHIFTR_ARITH);

    // Result for everything finishing on the accept edge; a zero-amount
    // shift simply passes operand A through.
    always_comb begin
        w_comb_res = '0;
        case (ALUControl)
            c_ALU_ADD:               w_comb_res = SrcA + SrcB;
            c_ALU_SUB:               w_comb_res = SrcA - SrcB;
            c_ALU_XOR:               w_comb_res = SrcA ^ SrcB;
            c_ALU_OR:                w_comb_res = SrcA | SrcB;
            c_ALU_AND:               w_comb_res = SrcA & SrcB;
            c_ALU_LESS_THAN_SIGNED:  w_comb_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            c_ALU_LESS_THAN:         w_comb_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            c_ALU_SHIFTL,
            c_ALU_SHIFTR,
            c_ALU_SHIFTR_ARITH:      w_comb_res = SrcA;
            default:                 w_comb_res = '0;
        endcase
    end

    always_comb begin
        w_step = r_work;
        case (r_ctrl)
            c_ALU_SHIFTL:       w_step = {r_work[XLEN-2:0], 1'b0};
            c_ALU_SHIFTR:       w_step = {1'b0, r_work[XLEN-1:1]};
            c_ALU_SHIFTR_ARITH: w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default:            w_step = r_work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_ctrl   <= c_ALU_NONE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_ctrl <= ALUControl;
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_work  <= SrcA;
                            r_cnt   <= w_shamt;
                            r_state <= c_S_SHIFT;
                        end else begin
                            r_result <= w_comb_res;
                            r_zero   <= (w_comb_res == '0);
                            r_state  <= c_S_DONE;
                        end
                    end
                end
                c_S_SHIFT: begin
                    if (r_cnt == c_CNT_ONE) begin
                        r_result <= w_step;
                        r_zero   <= (w_step == '0);
                        r_cnt    <= '0;
                        r_state  <= c_S_DONE;
                    end else begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt - c_CNT_ONE;
                    end
                end
                c_S_DONE: begin
                    if (out_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == c_S_IDLE);
    assign out_valid = (r_state == c_S_DONE);
    assign busy      = (r_state != c_S_IDLE);
    assign ALUResult = r_result;
    assign Zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iterative
// Brief    : Self-checking bench: directed vector table, random ops against a
//            plain-arithmetic model, back-pressure and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iterative;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_iterative #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic, shifts done in a single operator.
    function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
        if (c == OP_SLL || c == OP_SRL || c == OP_SRA) return 1 + int'(b % 32);
        return 1;
    endfunction

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!in_ready && k < 60) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: in_ready timeout got 0 expected 1", name);
        end
    endtask

    // Accept one op, scramble inputs afterwards, measure latency, check, drain.
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez, input int el);
        int k;
        wait_ready(name);
        in_valid   = 1'b1;
        ALUControl = c;
        SrcA       = a;
        SrcB       = b;
        tick();
        in_valid   = 1'b0;
        ALUControl = 4'($urandom);
        SrcA       = $urandom;
        SrcB       = $urandom;
        k = 1;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        check({name, " latency"}, 32'(k), 32'(el));
        check({name, " result"}, ALUResult, er);
        check({name, " zero"}, {31'd0, Zero}, {31'd0, ez});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b, r;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUControl = OP_NONE; SrcA = '0; SrcB = '0;

        vecs.push_back('{OP_ADD,  32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1'b0, 1});
        vecs.push_back('{OP_SUB,  32'd5,         32'd5,          32'd0,         1'b1, 1});
        vecs.push_back('{OP_SRA,  32'h8000_0010, 32'hFFFF_FFE4,  32'hF800_0001, 1'b0, 5});
        vecs.push_back('{OP_SRL,  32'h8000_0010, 32'hFFFF_FFE4,  32'h0800_0001, 1'b0, 5});
        vecs.push_back('{OP_SLL,  32'd1,         32'd31,         32'h8000_0000, 1'b0, 32});
        vecs.push_back('{OP_SLL,  32'd1,         32'd0,          32'd1,         1'b0, 1});
        vecs.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'd1,          32'd1,         1'b0, 1});
        vecs.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'd1,          32'd0,         1'b1, 1});
        vecs.push_back('{OP_XOR,  32'h1234_5678, 32'h1234_5678,  32'd0,         1'b1, 1});
        vecs.push_back('{OP_OR,   32'hF0F0_0000, 32'h0000_0F0F,  32'hF0F0_0F0F, 1'b0, 1});
        vecs.push_back('{OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0,  32'h0F00_0F00, 1'b0, 1});
        vecs.push_back('{OP_SLL,  32'h0000_0001, 32'hFFFF_FFE1,  32'h0000_0002, 1'b0, 2});
        vecs.push_back('{OP_SRA,  32'h4000_0000, 32'd30,         32'd1,         1'b0, 31});
        vecs.push_back('{4'hF,    32'hDEAD_BEEF, 32'h1,          32'd0,         1'b1, 1});

        // Reset state, including in_ready gated by rst_n.
        tick(); tick();
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", ALUResult, 32'd0);
        check("reset zero", {31'd0, Zero}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].zero, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            r = ref_res(c, a, b);
            run_op($sformatf("rand%0d", i), c, a, b, r, (r == 32'd0), ref_lat(c, b));
        end

        // Back-pressure: result frozen while inputs churn.
        wait_ready("bp");
        in_valid = 1'b1; ALUControl = OP_ADD; SrcA = 32'd3; SrcB = 32'd4;
        tick();
        for (int i = 0; i < 10; i++) begin
            SrcA = $urandom; SrcB = $urandom; ALUControl = OP_SUB;
            tick();
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp result", ALUResult, 32'd7);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("bp zero", {31'd0, Zero}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);

        // Reset at T+6 during a 20-bit shift: aborted, no late out_valid.
        in_valid = 1'b1; ALUControl = OP_SLL; SrcA = 32'd1; SrcB = 32'd20;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort result", ALUResult, 32'd0);
        check("abort zero", {31'd0, Zero}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 25; i++) begin
                tick();
                if (out_valid) seen++;
            end
            check("abort no pulse", 32'(seen), 32'd0);
        end
        run_op("none after abort", OP_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
